uart_tx_controller: RTL and testbench
=====================================

UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, byte queue depth (power of two, 2..16).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 tx_valid  in  1  requester has a byte.
REQ-005 tx_data  in  8  byte to transmit.
REQ-006 tx_ready  out  1  controller accepts byte this cycle.
REQ-007 baud_div  in  16  clk cycles per baud_clk_16 tick, minus one.
REQ-008 baud_clk_16  out  1  one-clk-wide 16x-baud tick to shift register.
REQ-009 sr_load  out  1  load strobe to shift register.
REQ-010 sr_data  out  8  byte presented to shift register data_in.
REQ-011 sr_done  in  1  shift register frame-complete flag.
REQ-012 busy  out  1  FSM not IDLE or FIFO non-empty.
REQ-013 fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes queued.

Function
REQ-014 Baud counter SHALL count 0..baud_div, pulse baud_clk_16 for one clk when count >= baud_div, then wrap to 0; baud_div=0 SHALL give a pulse every clk.
REQ-015 A baud_div change SHALL take effect without reset; a count already >= new baud_div SHALL pulse and wrap next cycle.
REQ-016 tx_ready SHALL equal (fifo_count < FIFO_DEPTH), combinational from registered state only.
REQ-017 Push SHALL occur on tx_valid && tx_ready; data accepted in order, no loss, no duplication.
REQ-018 Simultaneous push and pop SHALL leave fifo_count unchanged; push while full SHALL be impossible (tx_ready low).
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 FSM states: IDLE, LOAD, SEND, GAP.
REQ-021 IDLE: if FIFO non-empty, pop head into sr_data register, go LOAD next clk; else stay.
REQ-022 LOAD: sr_load=1; stay until a cycle with baud_clk_16=1, then go SEND (sr_load low from next clk); sr_data SHALL stay stable through LOAD.
REQ-023 SEND: sr_load=0; sr_done SHALL be ignored until one baud_clk_16 tick has occurred in SEND; thereafter sr_done=1 goes GAP.
REQ-024 GAP: wait one baud_clk_16 tick, then IDLE (guarantees sr_done cleared before next load).
REQ-025 Back-to-back bytes: next LOAD SHALL start at most 1 clk after GAP exit when FIFO non-empty.
REQ-026 sr_data SHALL change only on IDLE->LOAD transition.
REQ-027 busy SHALL be 0 only when state=IDLE and fifo_count=0.

Reset
REQ-028 On reset: state=IDLE, FIFO emptied, fifo_count=0, baud counter=0, baud_clk_16=0, sr_load=0, sr_data=8'h00, busy=0, tx_ready=1 (after reset deasserts).
REQ-029 Reset mid-frame SHALL abort immediately; queued bytes are discarded; no sr_load pulse SHALL follow reset until a new push.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state enum, DATA_W=8, default FIFO_DEPTH.
REQ-031 Baud tick generator SHALL be a separate sub-module uart_baud_gen (clk, reset, baud_div, tick); FIFO and FSM remain in uart_tx_controller.
REQ-032 All registers SHALL be in the clk domain with synchronous reset; no latches.

Verification
REQ-033 baud_div=9, no traffic -> baud_clk_16 pulses exactly every 10 clks, one clk wide.
REQ-034 Push 8'hDE with shift_register attached, baud_div=3 -> sr_load high until first tick, sr_data=8'hDE, serial line shows 0,01111011,1 LSB-first, busy falls after GAP.
REQ-035 Push 8'hDE, 8'hCA, 8'h55, 8'hA5, 8'h0F while sr_done held 0 (FIFO_DEPTH=4) -> tx_ready low after queue fills, fifo_count=4 max, then bytes emitted in order DE,CA,55,A5,0F once done pulses resume.
REQ-036 sr_done forced 1 continuously -> each byte still passes LOAD, one tick in SEND, GAP; no byte skipped.
REQ-037 Assert reset for 1 clk mid-SEND with 3 bytes queued -> next clk state IDLE, fifo_count=0, sr_load=0, no further loads.
REQ-038 Change baud_div 15->2 while counter=10 -> tick on next clk, then every 3 clks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit controller.
package uart_pkg;

  localparam int DATA_W         = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  // Transmit sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// 16x-baud tick generator: one-clk pulse every (baud_div + 1) clocks.
// The divisor is compared live, so a reduced divisor takes effect at once.
module uart_baud_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] baud_div,
  output logic        tick
);

  logic [15:0] r_count;
  logic        r_tick;
  logic        w_wrap;

  // A count at or beyond the divisor wraps, which also covers a divisor
  // that was lowered below the current count.
  assign w_wrap = (r_count >= baud_div);

  // Free-running counter with a registered tick output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick  <= w_wrap;
      r_count <= w_wrap ? 16'd0 : r_count + 16'd1;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/uart_tx_controller.sv
// UART transmit controller: byte FIFO in front of a sequencer that hands
// bytes to an external shift register, paced by the 16x-baud tick.
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_valid,
  input  logic [DATA_W-1:0]             tx_data,
  output logic                          tx_ready,
  input  logic [15:0]                   baud_div,
  output logic                          baud_clk_16,
  output logic                          sr_load,
  output logic [DATA_W-1:0]             sr_data,
  input  logic                          sr_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  tx_state_t         r_state;
  tx_state_t         w_state_next;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_sr_data;
  logic              r_send_ticked;
  logic              w_send_ticked_next;
  logic              w_tick;
  logic              w_push;
  logic              w_pop;
  logic              w_sr_load;
  logic              w_fifo_empty;

  uart_baud_gen u_baud_gen (
    .clk      (clk),
    .reset    (reset),
    .baud_div (baud_div),
    .tick     (w_tick)
  );

  assign w_fifo_empty = (r_count == '0);
  assign tx_ready     = (r_count < CW'(FIFO_DEPTH));
  assign w_push       = tx_valid && tx_ready;

  // FIFO storage; contents need no reset because the pointers and count do.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth makes pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Byte presented to the shift register; only updated when a byte is popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr_data <= '0;
    end else if (w_pop) begin
      r_sr_data <= r_mem[r_rd_ptr];
    end
  end

  // Sequencer state and the "tick seen while in SEND" flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_send_ticked <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_send_ticked <= w_send_ticked_next;
    end
  end

  // Next-state and strobe decode. sr_done is only trusted once a tick has
  // passed in SEND, so a stale done from the previous frame cannot end it.
  always_comb begin
    w_state_next       = r_state;
    w_send_ticked_next = r_send_ticked;
    w_pop              = 1'b0;
    w_sr_load          = 1'b0;
    case (r_state)
      IDLE: begin
        w_send_ticked_next = 1'b0;
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        w_sr_load          = 1'b1;
        w_send_ticked_next = 1'b0;
        if (w_tick) begin
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (r_send_ticked && sr_done) begin
          w_state_next = GAP;
        end else if (w_tick) begin
          w_send_ticked_next = 1'b1;
        end
      end
      GAP: begin
        if (w_tick) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign baud_clk_16 = w_tick;
  assign sr_load     = w_sr_load;
  assign sr_data     = r_sr_data;
  assign busy        = (r_state != IDLE) || !w_fifo_empty;
  assign fifo_count  = r_count;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed testbench for uart_tx_controller with a behavioural shift register.
`timescale 1ns/1ps
module tb_uart_tx_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [15:0] baud_div;
  logic        baud_clk_16;
  logic        sr_load;
  logic [7:0]  sr_data;
  logic        sr_done;
  logic        busy;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  int done_mode = 0;   // 0: shift register model, 1: forced low, 2: forced high
  int cyc = 0;

  always #5 clk = ~clk;

  uart_tx_controller #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .baud_div    (baud_div),
    .baud_clk_16 (baud_clk_16),
    .sr_load     (sr_load),
    .sr_data     (sr_data),
    .sr_done     (sr_done),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  // Behavioural shift register: 10-bit frame, 16 ticks per bit, sampled mid-bit.
  logic [9:0] m_frame = '0;
  int         m_bit = 0;
  int         m_sub = 0;
  logic       m_active = 1'b0;
  logic       m_done = 1'b0;
  logic       cap [0:1023];
  int         cap_n = 0;
  logic [7:0] load_log [0:31];
  int         load_time [0:31];
  int         load_n = 0;

  assign sr_done = (done_mode == 0) ? m_done : (done_mode == 2);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_bit    <= 0;
      m_sub    <= 0;
    end else if (baud_clk_16) begin
      if (sr_load) begin
        m_frame  <= {1'b1, sr_data, 1'b0};
        m_bit    <= 0;
        m_sub    <= 0;
        m_active <= 1'b1;
        m_done   <= 1'b0;
      end else if (m_active) begin
        if (m_sub == 7) begin
          cap[cap_n & 1023] <= m_frame[m_bit];
          cap_n <= cap_n + 1;
        end
        if (m_sub == 15) begin
          m_sub <= 0;
          if (m_bit == 9) begin
            m_active <= 1'b0;
            m_done   <= 1'b1;
          end else begin
            m_bit <= m_bit + 1;
          end
        end else begin
          m_sub <= m_sub + 1;
        end
      end
    end
  end

  // Log every byte the shift register actually accepts.
  always @(posedge clk) begin
    if (!reset && sr_load && baud_clk_16) begin
      load_log[load_n & 31]  <= sr_data;
      load_time[load_n & 31] <= cyc;
      load_n <= load_n + 1;
    end
  end

  task automatic wait_tick(input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!baud_clk_16 && n < lim);
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; baud_div = 16'd9; done_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count got %0d exp 0", fifo_count); end
    n_checks++; if (sr_load !== 1'b0) begin n_fail++; $display("FAIL reset_sr_load got %b exp 0", sr_load); end
    n_checks++; if (sr_data !== 8'h00) begin n_fail++; $display("FAIL reset_sr_data got %h exp 00", sr_data); end
    n_checks++; if (baud_clk_16 !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b exp 0", baud_clk_16); end
    $display("test_reset done");
  endtask

  task automatic test_baud_period;
    int n;
    // Counter starts at 0 after reset, so the first tick lands 10 clocks later.
    wait_tick(50, n);
    n_checks++; if (n != 10) begin n_fail++; $display("FAIL baud_first_tick got %0d clks exp 10", n); end
    for (int k = 0; k < 3; k++) begin
      wait_tick(50, n);
      n_checks++; if (n != 10) begin n_fail++; $display("FAIL baud_period_%0d got %0d clks exp 10", k, n); end
      $display("baud period %0d: %0d clks", k, n);
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL baud_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_baud_change;
    int n;
    bit stray;
    baud_div = 16'd15;
    wait_tick(40, n);
    stray = 0;
    // Count just wrapped to 0; step it to 10 with no tick expected.
    repeat (10) begin
      @(negedge clk);
      if (baud_clk_16) stray = 1;
    end
    n_checks++; if (stray) begin n_fail++; $display("FAIL baud_change_pre got tick exp none"); end
    baud_div = 16'd2;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_checks++;
      if (baud_clk_16 !== ((i % 3) == 0)) begin
        n_fail++;
        $display("FAIL baud_change_cyc%0d got %b exp %b", i, baud_clk_16, ((i % 3) == 0));
      end
    end
    $display("test_baud_change done");
  endtask

  task automatic test_single_frame;
    int n;
    int cap_base;
    int load_base;
    bit saw_tick;
    bit bad;
    logic [9:0] got;
    logic [9:0] exp_frame;
    exp_frame = {1'b1, 8'hDE, 1'b0};
    baud_div = 16'd3;
    done_mode = 0;
    cap_base = cap_n;
    load_base = load_n;
    push(8'hDE);
    n = 0;
    while (!sr_load && n < 20) begin @(negedge clk); n++; end
    n_checks++; if (sr_load !== 1'b1) begin n_fail++; $display("FAIL frame_load_start got %b exp 1", sr_load); end
    n_checks++; if (sr_data !== 8'hDE) begin n_fail++; $display("FAIL frame_sr_data got %h exp DE", sr_data); end
    n = 0; saw_tick = 0; bad = 0;
    while (sr_load && !saw_tick && n < 40) begin
      if (sr_data !== 8'hDE) bad = 1;
      if (baud_clk_16) saw_tick = 1;
      @(negedge clk);
      n++;
    end
    n_checks++; if (!saw_tick) begin n_fail++; $display("FAIL frame_load_until_tick got no tick exp tick"); end
    n_checks++; if (sr_load !== 1'b0) begin n_fail++; $display("FAIL frame_load_drop got %b exp 0", sr_load); end
    n_checks++; if (bad) begin n_fail++; $display("FAIL frame_data_stable got change exp stable"); end
    n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy_fall got %b exp 0", busy); end
    n_checks++; if (m_done !== 1'b1) begin n_fail++; $display("FAIL frame_done_before_idle got %b exp 1", m_done); end
    got = '0;
    for (int i = 0; i < 10; i++) got[i] = cap[(cap_base + i) & 1023];
    n_checks++; if ((cap_n - cap_base) != 10) begin n_fail++; $display("FAIL frame_bit_count got %0d exp 10", cap_n - cap_base); end
    n_checks++; if (got !== exp_frame) begin n_fail++; $display("FAIL frame_bits got %b exp %b", got, exp_frame); end
    n_checks++; if ((load_n - load_base) != 1) begin n_fail++; $display("FAIL frame_loads got %0d exp 1", load_n - load_base); end
    $display("frame DE serial (bit0 first reversed view) %b", got);
  endtask

  task automatic test_fifo_fill;
    int n;
    int load_base;
    logic [7:0] exp_bytes [0:4];
    exp_bytes[0] = 8'hDE; exp_bytes[1] = 8'hCA; exp_bytes[2] = 8'h55;
    exp_bytes[3] = 8'hA5; exp_bytes[4] = 8'h0F;
    done_mode = 1;
    baud_div = 16'd3;
    load_base = load_n;
    for (int i = 0; i < 5; i++) push(exp_bytes[i]);
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready got %b exp 0", tx_ready); end
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d exp 4", fifo_count); end
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    repeat (3) @(negedge clk);
    tx_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL fill_overpush got %0d exp 4", fifo_count); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy got %b exp 1", busy); end
    done_mode = 0;
    n = 0;
    while ((busy || (load_n - load_base) < 5) && n < 10000) begin @(negedge clk); n++; end
    n_checks++; if ((load_n - load_base) != 5) begin n_fail++; $display("FAIL fill_loads got %0d exp 5", load_n - load_base); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (load_log[(load_base + i) & 31] !== exp_bytes[i]) begin
        n_fail++;
        $display("FAIL fill_order_%0d got %h exp %h", i, load_log[(load_base + i) & 31], exp_bytes[i]);
      end
      $display("fill byte %0d: %h", i, load_log[(load_base + i) & 31]);
    end
  endtask

  task automatic test_done_forced;
    int n;
    int load_base;
    logic [7:0] exp_bytes [0:2];
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
    done_mode = 2;
    baud_div = 16'd1;
    load_base = load_n;
    for (int i = 0; i < 3; i++) push(exp_bytes[i]);
    n = 0;
    while ((busy || (load_n - load_base) < 3) && n < 500) begin @(negedge clk); n++; end
    n_checks++; if ((load_n - load_base) != 3) begin n_fail++; $display("FAIL forced_loads got %0d exp 3", load_n - load_base); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (load_log[(load_base + i) & 31] !== exp_bytes[i]) begin
        n_fail++;
        $display("FAIL forced_order_%0d got %h exp %h", i, load_log[(load_base + i) & 31], exp_bytes[i]);
      end
    end
    // Accept tick, one tick in SEND, one in GAP, one IDLE clk, next tick: 6 clks at div 1.
    for (int i = 1; i < 3; i++) begin
      n = load_time[(load_base + i) & 31] - load_time[(load_base + i - 1) & 31];
      n_checks++;
      if (n != 6) begin n_fail++; $display("FAIL forced_spacing_%0d got %0d exp 6", i, n); end
      $display("forced byte %0d spacing %0d clks", i, n);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int load_base;
    int loads_seen;
    done_mode = 1;
    baud_div = 16'd3;
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    n = 0;
    while (!sr_load && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (sr_load && n < 40) begin @(negedge clk); n++; end
    n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL midrst_pre_count got %0d exp 3", fifo_count); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL midrst_count got %0d exp 0", fifo_count); end
    n_checks++; if (sr_load !== 1'b0) begin n_fail++; $display("FAIL midrst_sr_load got %b exp 0", sr_load); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", busy); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b exp 1", tx_ready); end
    n_checks++; if (sr_data !== 8'h00) begin n_fail++; $display("FAIL midrst_sr_data got %h exp 00", sr_data); end
    load_base = load_n;
    loads_seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (sr_load) loads_seen++;
    end
    n_checks++; if (loads_seen != 0) begin n_fail++; $display("FAIL midrst_no_load got %0d exp 0", loads_seen); end
    done_mode = 2;
    push(8'h5A);
    n = 0;
    while ((load_n - load_base) < 1 && n < 100) begin @(negedge clk); n++; end
    n_checks++; if (load_log[load_base & 31] !== 8'h5A) begin n_fail++; $display("FAIL midrst_new_byte got %h exp 5A", load_log[load_base & 31]); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_baud_period();
    test_baud_change();
    test_single_frame();
    test_fifo_fill();
    test_done_forced();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
